// File: rtl/c17_bist_ctrl.sv
// BIST controller for the ISCAS c17 circuit: walks all 32 input patterns,
// compacts the two responses into an 8-bit MISR and compares with a golden signature.
module c17_bist_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] exp_sig,
    input  logic       N22,
    input  logic       N23,
    output logic       N1,
    output logic       N2,
    output logic       N3,
    output logic       N6,
    output logic       N7,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sig,
    output logic [4:0] pat_idx
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        CAPTURE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [4:0] LAST_PAT = 5'd31;
    localparam logic [7:0] SIG_SEED = 8'hFF;

    state_t     state;
    logic [4:0] stim;

    // Internal-XOR MISR for x^8+x^4+x^3+x^2+1, responses folded into bits 1:0.
    function automatic logic [7:0] misr_next(input logic [7:0] s,
                                             input logic       r22,
                                             input logic       r23);
        logic [7:0] n;
        n[0]   = s[7] ^ r22;
        n[1]   = s[0] ^ r23;
        n[2]   = s[1] ^ s[7];
        n[3]   = s[2] ^ s[7];
        n[4]   = s[3] ^ s[7];
        n[7:5] = s[6:4];
        return n;
    endfunction

    // Stimulus comes straight from a register, so c17 sees glitch-free inputs.
    assign {N1, N2, N3, N6, N7} = stim;

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking '=' would let later lines see new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            stim    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            sig     <= '0;
            pat_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        stim  <= '0;
                    end else if (start) begin
                        state   <= APPLY;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        sig     <= SIG_SEED;
                        pat_idx <= '0;
                        stim    <= '0;
                    end
                end

                APPLY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        stim  <= '0;
                    end else begin
                        state <= CAPTURE;
                    end
                end

                // Responses have had a full cycle to settle by the CAPTURE exit edge.
                CAPTURE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        stim  <= '0;
                    end else begin
                        sig <= misr_next(sig, N22, N23);
                        if (pat_idx == LAST_PAT) begin
                            state <= COMPARE;
                            stim  <= '0;
                        end else begin
                            state   <= APPLY;
                            pat_idx <= pat_idx + 5'd1;
                            stim    <= pat_idx + 5'd1;
                        end
                    end
                end

                COMPARE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        stim  <= '0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sig == exp_sig);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    stim  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl: a c17 gate model (optionally faulted or
// replaced by a random response table) drives the responses; signatures come from a reference model.
module tb_c17_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] exp_sig;
    logic       N22, N23;
    logic       N1, N2, N3, N6, N7;
    logic       busy, done, pass;
    logic [7:0] sig;
    logic [4:0] pat_idx;

    int          n_pass;
    int          n_total;
    int          resp_mode;   // 0 = c17, 1 = c17 with N22 stuck at 0, 2 = random table
    logic [63:0] resp_tbl;
    logic [1:0]  resp;
    logic [20:0] snap;

    c17_bist_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .exp_sig (exp_sig),
        .N22     (N22),
        .N23     (N23),
        .N1      (N1),
        .N2      (N2),
        .N3      (N3),
        .N6      (N6),
        .N7      (N7),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .sig     (sig),
        .pat_idx (pat_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // c17 netlist as six NAND gates; v = {N1,N2,N3,N6,N7}, result = {N23,N22}.
    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[4] & v[2]);
        n11 = ~(v[2] & v[1]);
        n16 = ~(v[3] & n11);
        n19 = ~(n11 & v[0]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [1:0] model_resp(input logic [4:0] v, input int mode,
                                              input logic [63:0] tbl);
        logic [1:0] r;
        r = c17(v);
        if (mode == 1) r[0] = 1'b0;
        if (mode == 2) r = tbl[2*v +: 2];
        return r;
    endfunction

    // Signature after the first npat patterns: multiply by x modulo the
    // feedback polynomial (0x1D), then add in the response pair.
    function automatic logic [7:0] model_sig(input int mode, input logic [63:0] tbl,
                                             input int npat);
        logic [7:0] s;
        logic [4:0] pv;
        s = 8'hFF;
        for (int p = 0; p < npat; p++) begin
            pv = p[4:0];
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'd0, model_resp(pv, mode, tbl)};
        end
        return s;
    endfunction

    assign resp = model_resp({N1, N2, N3, N6, N7}, resp_mode, resp_tbl);
    assign N22  = resp[0];
    assign N23  = resp[1];
    assign snap = {busy, done, pass, N1, N2, N3, N6, N7, pat_idx, sig};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run from start; optionally pulses start again while the given pattern is in APPLY.
    task automatic run_full(input string name, input int mode, input logic [7:0] exp,
                            input int busy_start_pat);
        logic [7:0]  final_sig;
        logic        exp_pass;
        logic [20:0] want;
        logic [4:0]  k5;
        resp_mode = mode;
        final_sig = model_sig(mode, resp_tbl, 32);
        exp_pass  = (final_sig == exp);
        exp_sig   = exp;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            k5   = k[4:0];
            want = {1'b1, 1'b0, 1'b0, k5, k5, model_sig(mode, resp_tbl, k)};
            n_total++;
            if (snap !== want)
                $display("FAIL %s apply pat %0d: got %h want %h", name, k, snap, want);
            else n_pass++;
            if (k == busy_start_pat) start = 1'b1;
            tick();
            start = 1'b0;
            n_total++;
            if (snap !== want)
                $display("FAIL %s capture pat %0d: got %h want %h", name, k, snap, want);
            else n_pass++;
            tick();
        end
        want = {1'b1, 1'b0, 1'b0, 5'd0, 5'd31, final_sig};
        n_total++;
        if (snap !== want) $display("FAIL %s compare: got %h want %h", name, snap, want);
        else n_pass++;
        tick();
        want = {1'b0, 1'b1, exp_pass, 5'd0, 5'd31, final_sig};
        n_total++;
        if (snap !== want) $display("FAIL %s done: got %h want %h", name, snap, want);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (snap !== want) $display("FAIL %s done hold: got %h want %h", name, snap, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if (snap !== 21'd0) $display("FAIL reset_initial: got %h want %h", snap, 21'd0);
        else n_pass++;
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        tick();
        n_total++;
        if (snap !== 21'd0) $display("FAIL reset_release_idle: got %h want %h", snap, 21'd0);
        else n_pass++;
    endtask

    task automatic test_golden();
        run_full("golden", 0, model_sig(0, resp_tbl, 32), -1);
    endtask

    task automatic test_fault();
        logic [7:0] good;
        good = model_sig(0, resp_tbl, 32);
        run_full("fault_n22_sa0", 1, good, -1);
        n_total++;
        if (sig === good || pass !== 1'b0)
            $display("FAIL fault_detect: sig %h pass %b, golden %h must differ with pass 0",
                     sig, pass, good);
        else n_pass++;
    endtask

    task automatic test_random_resp();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            resp_tbl = {$urandom, $urandom};
            exp = ($urandom_range(0, 1) == 1) ? model_sig(2, resp_tbl, 32) : 8'($urandom);
            run_full("random_resp", 2, exp, -1);
        end
        resp_tbl = '0;
    endtask

    task automatic test_abort();
        logic [20:0] want;
        int          e;
        logic [4:0]  p5;
        resp_mode = 0;
        exp_sig   = model_sig(0, resp_tbl, 32);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        want = {1'b1, 1'b0, 1'b0, 5'd10, 5'd10, model_sig(0, resp_tbl, 10)};
        n_total++;
        if (snap !== want) $display("FAIL abort_pre: got %h want %h", snap, want);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        want = {1'b0, 1'b0, 1'b0, 5'd0, 5'd10, model_sig(0, resp_tbl, 10)};
        n_total++;
        if (snap !== want) $display("FAIL abort_apply10: got %h want %h", snap, want);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (snap !== want) $display("FAIL abort_stay_idle: got %h want %h", snap, want);
        else n_pass++;
        run_full("after_abort", 0, exp_sig, -1);

        // Abort at a random point, possibly in CAPTURE or COMPARE.
        e = $urandom_range(1, 64);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < e; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        p5   = (e >= 64) ? 5'd31 : 5'(e / 2);
        want = {1'b0, 1'b0, 1'b0, 5'd0, p5, model_sig(0, resp_tbl, e / 2)};
        n_total++;
        if (snap !== want) $display("FAIL abort_edge_%0d: got %h want %h", e, snap, want);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        run_full("start_while_busy", 0, model_sig(0, resp_tbl, 32), 5);
    endtask

    task automatic test_start_abort_done();
        // Previous test leaves the block in DONE.
        n_total++;
        if (done !== 1'b1) $display("FAIL sa_pre_done: got %b want 1", done);
        else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_total++;
        if ({busy, done, N1, N2, N3, N6, N7} !== 7'd0)
            $display("FAIL start_abort_done: got %b want %b",
                     {busy, done, N1, N2, N3, N6, N7}, 7'd0);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL sa_stay_idle: got %b want 00", {busy, done});
        else n_pass++;
        run_full("rerun_after_sa", 0, model_sig(0, resp_tbl, 32), -1);
    endtask

    task automatic test_reset_mid_run();
        int  e;
        logic saw_done;
        e = $urandom_range(3, 60);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < e; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        n_total++;
        if (snap !== 21'd0) $display("FAIL reset_mid_run: got %h want %h", snap, 21'd0);
        else n_pass++;
        tick();
        #3 rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_total++;
        if (saw_done !== 1'b0) $display("FAIL reset_no_done: got %b want 0", saw_done);
        else n_pass++;
        run_full("after_reset", 0, model_sig(0, resp_tbl, 32), -1);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        resp_mode = 0;
        resp_tbl  = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        exp_sig   = 8'h00;
        test_reset();
        test_golden();
        test_fault();
        test_random_resp();
        test_abort();
        test_start_while_busy();
        test_start_abort_done();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/c17_bist_ctrl.md
C17_BIST_CTRL -- requirements
Module: c17_bist_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port start, input, 1 bit: run request, sampled only in IDLE or DONE.
REQ-004 The block SHALL have the port abort, input, 1 bit: cancels a run in progress.
REQ-005 The block SHALL have the port exp_sig, input, 8 bits: golden signature, compared in COMPARE.
REQ-006 The block SHALL have the ports N22 and N23, inputs, 1 bit each: c17 responses.
REQ-007 The block SHALL have the ports N1, N2, N3, N6 and N7, outputs, 1 bit each, registered: c17 stimulus.
REQ-008 The block SHALL have the port busy, output, 1 bit: high in APPLY, CAPTURE and COMPARE.
REQ-009 The block SHALL have the port done, output, 1 bit: high while in DONE.
REQ-010 The block SHALL have the port pass, output, 1 bit: result of the last completed run, valid while done is high.
REQ-011 The block SHALL have the port sig, output, 8 bits: current signature register (MISR).
REQ-012 The block SHALL have the port pat_idx, output, 5 bits: index of the current pattern.

Function
REQ-013 The FSM SHALL have the states IDLE, APPLY, CAPTURE, COMPARE and DONE.
REQ-014 In IDLE or DONE, start=1 and abort=0 SHALL cause the next state to be APPLY, with pat_idx=0, sig=8'hFF and pass=0.
REQ-015 In APPLY, {N1,N2,N3,N6,N7} SHALL equal pat_idx, with N1 as the MSB; the next state is CAPTURE.
REQ-016 In CAPTURE, the stimulus SHALL be held and the MISR SHALL fold in {N23,N22} at the CAPTURE-exit edge.
REQ-017 At the CAPTURE exit, if pat_idx is below 31, pat_idx SHALL increment and the next state is APPLY; if pat_idx is 31, pat_idx holds at 31 and the next state is COMPARE.
REQ-018 The MISR update SHALL be: n[0]=s[7]^N22, n[1]=s[0]^N23, n[2]=s[1]^s[7], n[3]=s[2]^s[7], n[4]=s[3]^s[7], n[7:5]=s[6:4] (polynomial x^8+x^4+x^3+x^2+1).
REQ-019 In COMPARE, pass SHALL be registered as (sig==exp_sig) and the next state is DONE.
REQ-020 In DONE, sig, pass and pat_idx SHALL hold until the next start.
REQ-021 Latency: the start-sampling edge is edge 0; the 32 patterns SHALL take 2 cycles each, COMPARE is entered after edge 64, and done=1 after edge 65.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 abort=1 in APPLY, CAPTURE or COMPARE SHALL give, at the next edge: IDLE, busy=0, done=0, pass=0 and stimulus 0; pat_idx and sig are left unchanged.
REQ-024 If start and abort are high together in IDLE or DONE, abort SHALL win and the next state is IDLE.
REQ-025 In IDLE and DONE, N1, N2, N3, N6 and N7 SHALL be driven 0.
REQ-026 The block SHALL sample N22 and N23 only at CAPTURE-exit edges; the responses are treated as settled one cycle after the stimulus changes.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, N1, N2, N3, N6 and N7=0, busy=0, done=0, pass=0, sig=8'h00 and pat_idx=0, regardless of clk.
REQ-028 Reset asserted mid-run SHALL abandon the run with no done pulse; after release the block waits in IDLE for start.
REQ-029 Deassertion of rst_n SHALL take effect at the first clk edge after release, with no spurious start.

Verification
REQ-030 Scenario, reset: assert rst_n=0 mid-cycle -> all outputs take their REQ-027 values before the next clk edge.
REQ-031 Scenario, golden run: c17 reference model connected, exp_sig set to the model signature, start pulsed -> stimulus steps 00000 to 11111 every 2 cycles, done=1 after edge 65, pass=1, busy=0.
REQ-032 Scenario, fault injection: N22 stuck at 0 in the model, same exp_sig -> done=1 after edge 65, pass=0, sig differs from exp_sig.
REQ-033 Scenario, abort: abort=1 for one cycle at pat_idx=10 in APPLY -> IDLE next edge, busy=0, done=0, stimulus 0; a new start then runs to a full pass.
REQ-034 Scenario, start while busy: start pulsed at pat_idx=5 -> no restart, pat_idx continues 6, 7, ...; done after edge 65 of the original start.
REQ-035 Scenario, start and abort together in DONE -> stays in IDLE, done=0; a later start alone gives a correct rerun.
